// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  // {CEB, WEB} encoding that leaves the macro untouched for a cycle.
  localparam logic [1:0] SRAM_CTRL_INACTIVE = 2'b11;

endpackage

// File: rtl/sram_1p_ctrl_if.sv
// Client-side request/response bundle of the single-port SRAM controller.
interface sram_1p_ctrl_if #(
  parameter int WIDTH = 3,
  parameter int AW    = 7
);
  logic             clear;
  logic             init_busy;
  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [AW-1:0]    rd_addr;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output clear, wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    input  init_busy, wr_ready, rd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  clear, wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    output init_busy, wr_ready, rd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sram_ctrl_rdhold.sv
// Read-response stage: tracks the outstanding read and holds the last returned
// word so consumers never observe the macro's undefined Q.
module sram_ctrl_rdhold #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             rd_fire,
  input  logic             rd_oob,
  input  logic [WIDTH-1:0] sram_q,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data
);
  logic             pend_q, pend_d;
  logic             oob_q, oob_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] rd_value;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      pend_q <= 1'b0;
      oob_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      pend_q <= pend_d;
      oob_q  <= oob_d;
      hold_q <= hold_d;
    end
  end

  always_comb begin
    pend_d   = rd_fire;
    oob_d    = rd_oob;
    // Out-of-range reads never touched the macro, so they answer with zero.
    rd_value = oob_q ? '0 : sram_q;
    hold_d   = pend_q ? rd_value : hold_q;
  end

  assign rsp_valid = pend_q;
  assign rsp_data  = pend_q ? rd_value : hold_q;

endmodule

// File: rtl/sram_1p_ctrl.sv
// Single-port SRAM controller: write-priority arbitration and held read data.
// Build option: define SRAM_CTRL_INIT_EN to zero-clear the array after reset and on clear.
module sram_1p_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             CLK,
  input  logic             RSTN,
  sram_1p_ctrl_if.slave    bus,
  output logic             sram_ceb,
  output logic             sram_web,
  output logic [AW-1:0]    sram_a,
  output logic [WIDTH-1:0] sram_d,
  input  logic [WIDTH-1:0] sram_q
);
  logic          sweep_active;
  logic          clear_eff;
  logic [AW-1:0] sweep_addr;

`ifdef SRAM_CTRL_INIT_EN
  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.clear) begin
      state_d = INIT;
      cnt_d   = '0;
    end else if (state_q == INIT) begin
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
  end

  assign sweep_active = (state_q == INIT);
  assign sweep_addr   = cnt_q;
  assign clear_eff    = bus.clear;
`else
  assign sweep_active = 1'b0;
  assign sweep_addr   = '0;
  assign clear_eff    = 1'b0;
`endif

  logic wr_fire, rd_fire;
  logic wr_in_range, rd_in_range;

  assign bus.init_busy = sweep_active;
  assign bus.wr_ready  = ~sweep_active & ~clear_eff;
  assign bus.rd_ready  = ~sweep_active & ~clear_eff & ~bus.wr_valid;

  assign wr_fire     = bus.wr_valid & bus.wr_ready;
  assign rd_fire     = bus.rd_valid & bus.rd_ready;
  assign wr_in_range = ({1'b0, bus.wr_addr} < (AW+1)'(DEPTH));
  assign rd_in_range = ({1'b0, bus.rd_addr} < (AW+1)'(DEPTH));

  always_comb begin
    {sram_ceb, sram_web} = SRAM_CTRL_INACTIVE;
    sram_a = '0;
    sram_d = '0;
    if (sweep_active) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = sweep_addr;
    end else if (wr_fire && wr_in_range) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = bus.wr_addr;
      sram_d   = bus.wr_data;
    end else if (rd_fire && rd_in_range) begin
      sram_ceb = 1'b0;
      sram_web = 1'b1;
      sram_a   = bus.rd_addr;
    end
  end

  sram_ctrl_rdhold #(
    .WIDTH (WIDTH)
  ) u_rdhold (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .rd_fire   (rd_fire),
    .rd_oob    (rd_fire & ~rd_in_range),
    .sram_q    (sram_q),
    .rsp_valid (bus.rsp_valid),
    .rsp_data  (bus.rsp_data)
  );

endmodule

// File: tb/tb_sram_1p_ctrl.sv
// Directed + random bench for sram_1p_ctrl with a macro model and a
// contents/handshake reference model.
module tb_sram_1p_ctrl;
  localparam int W = 3;
  localparam int D = 128;
  localparam int A = 7;
`ifdef SRAM_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif
  localparam int SWEEP_LEN = INIT_EN ? D : 0;

  logic         CLK;
  logic         RSTN;
  logic         sram_ceb, sram_web;
  logic [A-1:0] sram_a;
  logic [W-1:0] sram_d;
  logic [W-1:0] sram_q;

  sram_1p_ctrl_if #(.WIDTH(W), .AW(A)) bus ();

  sram_1p_ctrl #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .bus      (bus),
    .sram_ceb (sram_ceb),
    .sram_web (sram_web),
    .sram_a   (sram_a),
    .sram_d   (sram_d),
    .sram_q   (sram_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Macro model: Q is only meaningful the cycle after a read, garbage otherwise.
  logic [W-1:0] mem [D];
  always @(posedge CLK) begin
    if (!sram_ceb && !sram_web) mem[sram_a] <= sram_d;
    if (!sram_ceb && sram_web) sram_q <= mem[sram_a];
    else                       sram_q <= W'($urandom);
  end

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] ref_mem [D];
  bit           known   [D];
  int           busy_left;
  int           busy_obs;
  bit           rsp_pend;
  logic [W-1:0] rsp_exp;
  bit           rsp_known;
  logic [W-1:0] hold_exp;
  bit           hold_known;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTN = 1'b0;
    bus.clear = 1'b0; bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
    @(negedge CLK);
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    busy_left  = SWEEP_LEN;
    busy_obs   = 0;
    rsp_pend   = 1'b0;
    hold_exp   = '0;
    hold_known = 1'b1;
  endtask

  task automatic cycle(input logic wv, input logic [A-1:0] wa, input logic [W-1:0] wd,
                       input logic rv, input logic [A-1:0] ra, input logic clr);
    logic         clr_eff, e_wr, e_rd, e_ceb, e_web;
    logic [A-1:0] e_a;
    logic [W-1:0] e_d;
    @(negedge CLK);
    RSTN = 1'b1;
    bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_data = wd;
    bus.rd_valid = rv; bus.rd_addr = ra; bus.clear = clr;
    #1;
    if (rsp_pend) begin
      check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      if (rsp_known) check("rsp_data", 32'(bus.rsp_data), 32'(rsp_exp));
      hold_exp   = rsp_exp;
      hold_known = rsp_known;
    end else begin
      check("rsp_idle", 32'(bus.rsp_valid), 32'd0);
      if (hold_known) check("rsp_hold", 32'(bus.rsp_data), 32'(hold_exp));
    end
    clr_eff = clr & INIT_EN;
    e_wr = 1'b0; e_rd = 1'b0; e_ceb = 1'b1; e_web = 1'b1; e_a = '0; e_d = '0;
    if (bus.init_busy) busy_obs++;
    if (busy_left > 0) begin
      e_ceb = 1'b0; e_web = 1'b0; e_a = A'(D - busy_left);
      check("init_busy", 32'(bus.init_busy), 32'd1);
      check("wr_ready_busy", 32'(bus.wr_ready), 32'd0);
      check("rd_ready_busy", 32'(bus.rd_ready), 32'd0);
    end else begin
      check("init_busy_idle", 32'(bus.init_busy), 32'd0);
      check("wr_ready", 32'(bus.wr_ready), 32'(!clr_eff));
      check("rd_ready", 32'(bus.rd_ready), 32'(!clr_eff && !wv));
      e_wr = wv & !clr_eff;
      e_rd = rv & !wv & !clr_eff;
      if (e_wr) begin e_ceb = 1'b0; e_web = 1'b0; e_a = wa; e_d = wd; end
      else if (e_rd) begin e_ceb = 1'b0; e_a = ra; end
    end
    check("sram_pins", 32'({sram_ceb, sram_web, sram_a, sram_d}), 32'({e_ceb, e_web, e_a, e_d}));
    rsp_pend  = e_rd;
    rsp_exp   = ref_mem[ra];
    rsp_known = known[ra];
    if (busy_left > 0) begin
      ref_mem[e_a] = '0;
      known[e_a]   = 1'b1;
      busy_left--;
    end else if (e_wr) begin
      ref_mem[wa] = wd;
      known[wa]   = 1'b1;
    end
    if (clr_eff) busy_left = D;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d);
    cycle(1'b1, a, d, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input logic [A-1:0] a);
    cycle(1'b0, '0, '0, 1'b1, a, 1'b0);
  endtask

  task automatic finish_sweep();
    while (busy_left > 0) idle(1);
    check("sweep_len", 32'(busy_obs), 32'(SWEEP_LEN));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN = 1'b0;
    bus.clear = 1'b0; bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0;
    for (int i = 0; i < D; i++) begin ref_mem[i] = '0; known[i] = 1'b0; end

    // Reset sweep and zero readback
    do_reset();
    finish_sweep();
    rd(7'd0); rd(7'd64); rd(7'd127); idle(1);

    // Write then read, held across randomized Q
    wr(7'd5, 3'b101); rd(7'd5); idle(5);

    // Collision: write wins, read follows
    cycle(1'b1, 7'd9, 3'b011, 1'b1, 7'd9, 1'b0);
    rd(7'd9); idle(2);

    // Back-to-back reads
    wr(7'd1, 3'b001); wr(7'd2, 3'b010); wr(7'd3, 3'b100);
    rd(7'd1); rd(7'd2); rd(7'd3); idle(2);

    // Read just before clear, then clear with a write pending
    rd(7'd9);
    busy_obs = 0;
    cycle(1'b1, 7'd7, 3'b110, 1'b0, '0, 1'b1);
    finish_sweep();
    rd(7'd5); rd(7'd7); idle(1);

    // Reset in the middle of a sweep
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
    idle(40);
    do_reset();
    finish_sweep();
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), A'($urandom_range(0, D - 1)), W'($urandom),
            1'($urandom_range(0, 1)), A'($urandom_range(0, D - 1)),
            1'($urandom_range(0, 99) == 0));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_1p_ctrl.md
Name: sram_1p_ctrl

Overview:
- Controller in front of a single-port SRAM macro with active-low CEB/WEB, one-cycle read latency and non-deterministic Q on non-read cycles. Example instance: 128x3 predictor/meta table.
- Arbitrates read and write requests onto the single port and zero-clears the array after reset or on demand.
- Holds the last read data stable so consumers never sample the macro's undefined Q.

Parameters:
- WIDTH, 3, data bits per entry
- DEPTH, 128, number of entries
- AW, 7, address width; must equal clog2(DEPTH)

Ports:
- CLK  in  1  clock; all state updates on posedge
- RSTN  in  1  synchronous active-low reset
- clear  in  1  one-cycle pulse that restarts the zero-clear sweep
- init_busy  out  1  high while the sweep runs
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- rd_valid  in  1  read request
- rd_ready  out  1  read accepted when rd_valid & rd_ready
- rd_addr  in  AW  read address
- rsp_valid  out  1  one-cycle pulse; read data present on rsp_data
- rsp_data  out  WIDTH  read data, held until the next rsp_valid
- sram_ceb  out  1  macro chip enable, active-low
- sram_web  out  1  macro write enable, active-low (0 = write)
- sram_a  out  AW  macro address
- sram_d  out  WIDTH  macro write data
- sram_q  in  WIDTH  macro read data, valid only the cycle after a read

Behaviour:
- Interface: one clock; reset is synchronous and active-low (CLK, RSTN).
- States: INIT, IDLE.
- Reset, with RSTN=0 at a posedge:
  - state=INIT, init counter=0
  - rsp_valid=0, rsp_data=0, internal read-pending flag=0
- INIT:
  - sram_ceb=0, sram_web=0, sram_a=counter, sram_d=0; counter increments each cycle.
  - wr_ready=0, rd_ready=0, init_busy=1.
  - Counter reaching DEPTH-1 writes that last entry, then INIT->IDLE. A full sweep is exactly DEPTH cycles.
- IDLE:
  - init_busy=0, wr_ready=1, rd_ready = ~wr_valid. Write wins a collision; the read stalls that cycle.
  - Accepted write: ceb=0, web=0, a=wr_addr, d=wr_data.
  - Accepted read: ceb=0, web=1, a=rd_addr; read-pending flag set for the next cycle.
  - No request: ceb=1, web=1; a and d don't-care, driven 0.
- Read response:
  - The cycle after an accepted read, rsp_valid=1 and rsp_data=sram_q. The value is passed combinationally through and also captured into a hold register.
  - In all other cycles rsp_data = hold register and rsp_valid=0.
  - Back-to-back reads give one response per cycle.
- clear:
  - In IDLE or INIT, a clear pulse forces INIT with counter=0 on the next cycle.
  - A request on the same cycle as clear is not accepted: ready is deasserted combinationally when clear=1.
  - A read accepted the cycle before clear still delivers its response.
- Reset mid-sweep restarts the sweep at 0. Reset drops any pending read response; no rsp_valid follows.
- Addresses >= DEPTH (non-power-of-2 DEPTH): write ignored (ceb=1), read returns 0 with rsp_valid=1.

Optional Feature:
- Macro: SRAM_CTRL_INIT_EN.
- Defined: INIT sweep as above, after reset and on clear.
- Undefined:
  - No INIT state or counter; after reset the block starts in IDLE.
  - init_busy is tied to 0 and clear is ignored.
  - Array contents after reset are undefined.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - state enum (INIT, IDLE)
  - helper constant for the macro's inactive encoding (CEB=1, WEB=1)
- One natural sub-module: sram_ctrl_rdhold, containing the read-pending flag, hold register and rsp mux.
- Arbitration and the sweep FSM stay in the top module.

Test Plan:
- Reset sweep (INIT_EN defined): RSTN low 2 cycles, then high.
  - init_busy=1 for exactly 128 cycles; sram_a runs 0..127 with web=0, d=0.
  - Then ready=1; reading addresses 0, 64 and 127 returns 0.
- Write/read: write addr 5 data 3'b101, then read addr 5.
  - rsp_valid one cycle after acceptance, rsp_data=3'b101.
  - rsp_data still 3'b101 five idle cycles later while sram_q is randomized.
- Collision: wr_valid and rd_valid both high, same cycle (wr addr 9 data 3'b011, rd addr 9).
  - Write accepted, rd_ready=0.
  - Read accepted next cycle; response 3'b011.
- Back-to-back reads of addresses 1, 2, 3 holding 3'b001, 3'b010, 3'b100.
  - rsp_valid high 3 consecutive cycles with those values in order.
- Clear mid-traffic: pulse clear while wr_valid=1.
  - Write not accepted; init_busy rises next cycle for 128 cycles.
  - The previously written addr 5 afterwards reads 0.
- Reset mid-sweep at counter=40: sweep restarts at 0 and completes 128 cycles; no spurious rsp_valid.
